calc_cmd_issuer: RTL and testbench
==================================

Name: calc_cmd_issuer

Overview:
Initiator-side driver for the team's 16-bit sequential calculator. It accepts operation commands on a valid/ready interface and buffers them in a small FIFO. It drives the calculator's start/op/a/b level handshake, waits for done, and completes the return-to-idle handshake. It then returns each result, with its flags and command tag, in order on a valid/ready response interface. It sits between a host or bus adapter and the calculator instance.

Parameters:
TAG_W, 4, width of the command/response tag
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 64, max cycles in ISSUE before aborting (>=32)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full)
cmd_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
cmd_a  in  16  operand a
cmd_b  in  16  operand b
cmd_tag  in  TAG_W  returned unchanged with the response
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_result  out  16  calculator result
rsp_overflow  out  1  calculator overflow flag
rsp_error  out  1  calculator error flag (divide by zero)
rsp_timeout  out  1  done never seen
rsp_tag  out  TAG_W  tag of the command
calc_start  out  1  level start to calculator
calc_op  out  2  op to calculator
calc_a  out  16  operand a to calculator
calc_b  out  16  operand b to calculator
calc_result  in  16  from calculator
calc_overflow  in  1  from calculator
calc_error  in  1  from calculator
calc_done  in  1  from calculator
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - Every registered output is 0, including calc_start, calc_op/a/b and all rsp_* outputs.
  - FIFO is empty, state is IDLE, the timer is 0.
  - cmd_ready is 1 during and after reset.
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - Pop only on the IDLE->ISSUE transition.
  - Simultaneous push and pop is legal when full; count is unchanged and cmd_ready stays 0 that cycle (it is registered from count).
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE:
    - If FIFO is non-empty and calc_done==0, latch the head into calc_op/a/b and tag_q, pop, and go to ISSUE.
    - If calc_done==1 (stale), wait in IDLE.
  - ISSUE:
    - calc_start=1. calc_op/a/b are held stable for the whole state, because the calculator samples op every CALC cycle.
    - The timer increments each cycle.
    - If calc_done==1: capture calc_result/overflow/error into the rsp registers, set rsp_timeout=0, and go to RELEASE.
    - Else if timer==TIMEOUT_CYC-1: set rsp_result=0, rsp_overflow=0, rsp_error=0, rsp_timeout=1, and go to RELEASE.
    - calc_done has priority over timeout in the same cycle.
  - RELEASE:
    - calc_start=0.
    - Wait for calc_done==0, then go to RESP.
    - After a timeout, go straight to RESP when calc_done==0.
  - RESP:
    - rsp_valid=1. All rsp_* fields are stable while rsp_ready==0.
    - On rsp_ready, go to IDLE and clear rsp_valid.
- calc_start is registered and asserts in the cycle after the IDLE->ISSUE decision.
- Expected first done:
  - ADD/SUB: 3 cycles after calc_start rises.
  - MUL/DIV: about 19 cycles after calc_start rises.
- Ordering: responses leave in command order; only one command is outstanding.
- Mid-operation reset: outputs clear asynchronously, queued commands are discarded, and no response is produced for any pre-reset command.
- No arithmetic is done in this block. Results pass through unmodified.

Decomposition:
- Shared package calc_pkg holds:
  - op encodings: OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - FSM state encodings: IDLE, ISSUE, RELEASE, RESP
  - the command struct {op, a, b, tag}
- One sub-module, calc_cmd_fifo: a synchronous FIFO with parameters WIDTH and DEPTH and ports push/pop/full/empty/count. calc_cmd_issuer instantiates it with WIDTH = 34+TAG_W.

Test Plan:
- ADD a=0x1234, b=0x0111, tag=3, rsp_ready=1 -> rsp_result=0x1345, overflow=0, error=0, timeout=0, tag=3. calc_start stays high until calc_done, then drops; the next start only follows after calc_done falls.
- MUL a=300, b=300 -> rsp_result=0x5F90, rsp_overflow=1. calc_op/a/b stay constant throughout ISSUE.
- DIV a=100, b=0 -> rsp_error=1, rsp_result=0. A following DIV 100/7 -> result=14, error=0.
- Hold rsp_ready=0 and push commands tagged 0..N until cmd_ready=0:
  - exactly FIFO_DEPTH+1=5 are accepted;
  - rsp fields stay stable while stalled;
  - after releasing rsp_ready, tags return in order 0..4;
  - full+push is rejected with no corruption.
- Stub the calculator with calc_done stuck at 0 -> calc_start is high for exactly TIMEOUT_CYC=64 cycles, then rsp_timeout=1 and rsp_result=0. The next queued command still issues.
- Pull rst_n low 5 cycles into a MUL with 2 commands queued -> all outputs are 0 immediately and cmd_ready=1. After release, no rsp_valid appears without new commands.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared op/state encodings and command struct for the calculator issuer
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        RESP    = 2'd3
    } calc_state_e;

    // Operand part of a command; the tag travels next to it because its
    // width is a parameter of the issuer rather than a package constant.
    typedef struct packed {
        calc_op_e    op;
        logic [15:0] a;
        logic [15:0] b;
    } calc_cmd_t;

    localparam int CALC_CMD_W = $bits(calc_cmd_t);

endpackage

// File: rtl/calc_cmd_issuer_if.sv
// rtl/calc_cmd_issuer_if.sv - command and response valid/ready bundle of the issuer
interface calc_cmd_issuer_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [15:0]      cmd_a;
    logic [15:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic             rsp_overflow;
    logic             rsp_error;
    logic             rsp_timeout;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_overflow, rsp_error, rsp_timeout, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_overflow, rsp_error, rsp_timeout, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - synchronous command FIFO with occupancy count
module calc_cmd_fifo #(
    parameter int  WIDTH = 38,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/calc_cmd_issuer.sv
// rtl/calc_cmd_issuer.sv - queues calculator commands and drives the start/done level handshake
module calc_cmd_issuer
    import calc_pkg::*;
#(
    parameter int TAG_W       = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    calc_cmd_issuer_if.slave   host,
    output logic               calc_start,
    output logic [1:0]         calc_op,
    output logic [15:0]        calc_a,
    output logic [15:0]        calc_b,
    input  logic [15:0]        calc_result,
    input  logic               calc_overflow,
    input  logic               calc_error,
    input  logic               calc_done,
    output logic               busy
);
    localparam int FW      = CALC_CMD_W + TAG_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC);

    calc_state_e      state;
    logic [TIMER_W-1:0] timer;
    logic [TAG_W-1:0] tag_q;

    logic             rsp_valid_q;
    logic [15:0]      rsp_result_q;
    logic             rsp_overflow_q;
    logic             rsp_error_q;
    logic             rsp_timeout_q;
    logic [TAG_W-1:0] rsp_tag_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic [FW-1:0]    fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    calc_cmd_t        head_cmd;
    logic [TAG_W-1:0] head_tag;

    assign fifo_push = host.cmd_valid && host.cmd_ready;
    // A stale done from the previous operation must clear before a new one starts.
    assign fifo_pop  = (state == IDLE) && !fifo_empty && !calc_done;
    assign {head_cmd, head_tag} = fifo_head;

    calc_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({host.cmd_op, host.cmd_a, host.cmd_b, host.cmd_tag}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign host.cmd_ready    = !fifo_full;
    assign host.rsp_valid    = rsp_valid_q;
    assign host.rsp_result   = rsp_result_q;
    assign host.rsp_overflow = rsp_overflow_q;
    assign host.rsp_error    = rsp_error_q;
    assign host.rsp_timeout  = rsp_timeout_q;
    assign host.rsp_tag      = rsp_tag_q;
    assign busy              = (state != IDLE) || (fifo_count != '0);

    // Issue FSM: one command outstanding, operands held for the whole ISSUE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            timer          <= '0;
            tag_q          <= '0;
            calc_start     <= 1'b0;
            calc_op        <= '0;
            calc_a         <= '0;
            calc_b         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            rsp_tag_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        calc_op    <= head_cmd.op;
                        calc_a     <= head_cmd.a;
                        calc_b     <= head_cmd.b;
                        tag_q      <= head_tag;
                        timer      <= '0;
                        calc_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= timer + 1'b1;
                    if (calc_done) begin
                        rsp_result_q   <= calc_result;
                        rsp_overflow_q <= calc_overflow;
                        rsp_error_q    <= calc_error;
                        rsp_timeout_q  <= 1'b0;
                        rsp_tag_q      <= tag_q;
                        calc_start     <= 1'b0;
                        state          <= RELEASE;
                    end else if (timer == TIMER_W'(TIMEOUT_CYC - 1)) begin
                        rsp_result_q   <= '0;
                        rsp_overflow_q <= 1'b0;
                        rsp_error_q    <= 1'b0;
                        rsp_timeout_q  <= 1'b1;
                        rsp_tag_q      <= tag_q;
                        calc_start     <= 1'b0;
                        state          <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!calc_done) begin
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (host.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_cmd_issuer.sv
// tb/tb_calc_cmd_issuer.sv - scoreboard bench for calc_cmd_issuer with a behavioural calculator stub
`timescale 1ns/1ps
module tb_calc_cmd_issuer;
    import calc_pkg::*;

    localparam int TAG_W       = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 64;

    typedef struct {
        logic [15:0]      result;
        logic             ovf;
        logic             err;
        logic             to;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        calc_start;
    logic [1:0]  calc_op;
    logic [15:0] calc_a;
    logic [15:0] calc_b;
    logic [15:0] calc_result;
    logic        calc_overflow;
    logic        calc_error;
    logic        calc_done;
    logic        busy;

    calc_cmd_issuer_if #(.TAG_W(TAG_W)) bus ();

    calc_cmd_issuer #(
        .TAG_W       (TAG_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host          (bus),
        .calc_start    (calc_start),
        .calc_op       (calc_op),
        .calc_a        (calc_a),
        .calc_b        (calc_b),
        .calc_result   (calc_result),
        .calc_overflow (calc_overflow),
        .calc_error    (calc_error),
        .calc_done     (calc_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    int   ready_mode = 0;
    int   model_stuck_left = 0;
    int   stub_stuck_left = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // What the calculator is supposed to return for one command.
    function automatic exp_t model(logic [1:0] op, logic [15:0] a, logic [15:0] b,
                                   logic [TAG_W-1:0] tag, bit stuck);
        exp_t        e;
        logic [31:0] wide;
        e.tag = tag; e.to = stuck; e.result = '0; e.ovf = 1'b0; e.err = 1'b0;
        if (!stuck) begin
            case (op)
                OP_ADD: begin wide = 32'(a) + 32'(b); e.result = wide[15:0]; e.ovf = wide[16]; end
                OP_SUB: begin e.result = a - b; e.ovf = (a < b); end
                OP_MUL: begin wide = 32'(a) * 32'(b); e.result = wide[15:0]; e.ovf = (wide[31:16] != 0); end
                default: begin
                    if (b == 16'd0) e.err = 1'b1;
                    else e.result = a / b;
                end
            endcase
        end
        return e;
    endfunction

    // Calculator stub: done rises after the op latency, lingers a few random cycles after start drops.
    int   stub_cnt, stub_hold, stub_lat;
    bit   stub_cur_stuck = 1'b0;
    logic stub_prev_start;
    initial begin
        exp_t r;
        calc_done = 1'b0; calc_result = '0; calc_overflow = 1'b0; calc_error = 1'b0;
        stub_cnt = 0; stub_hold = 0; stub_lat = 3; stub_prev_start = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                calc_done = 1'b0; stub_cnt = 0; stub_prev_start = 1'b0; stub_cur_stuck = 1'b0;
            end else begin
                if (calc_start && !stub_prev_start) begin
                    stub_cur_stuck = (stub_stuck_left > 0);
                    if (stub_stuck_left > 0) stub_stuck_left--;
                    stub_cnt = 0;
                    stub_lat = calc_op[1] ? 19 : 3;
                end
                if (!calc_done) begin
                    calc_result = 16'($urandom); calc_overflow = 1'($urandom); calc_error = 1'($urandom);
                end
                if (calc_start) begin
                    if (!stub_cur_stuck && !calc_done) begin
                        stub_cnt++;
                        if (stub_cnt >= stub_lat) begin
                            r = model(calc_op, calc_a, calc_b, '0, 1'b0);
                            calc_result = r.result; calc_overflow = r.ovf; calc_error = r.err;
                            calc_done = 1'b1;
                            stub_hold = $urandom_range(0, 3);
                        end
                    end
                end else if (calc_done) begin
                    if (stub_hold > 0) stub_hold--;
                    else calc_done = 1'b0;
                end
                stub_prev_start = calc_start;
            end
        end
    end

    // Response consumer.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // Response monitor: pops the scoreboard on every handshake and checks stall stability.
    bit   stall_seen = 1'b0;
    exp_t stall_v;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else if (bus.rsp_valid) begin
            if (stall_seen)
                check("rsp_hold", {bus.rsp_result, bus.rsp_overflow, bus.rsp_error, bus.rsp_timeout, bus.rsp_tag},
                      {stall_v.result, stall_v.ovf, stall_v.err, stall_v.to, stall_v.tag});
            if (bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rsp_unexpected: got tag %h, expected no response", bus.rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", {bus.rsp_result, bus.rsp_overflow, bus.rsp_error, bus.rsp_timeout, bus.rsp_tag},
                          {e.result, e.ovf, e.err, e.to, e.tag});
                end
                stall_seen = 1'b0;
            end else begin
                stall_seen = 1'b1;
                stall_v.result = bus.rsp_result; stall_v.ovf = bus.rsp_overflow;
                stall_v.err = bus.rsp_error; stall_v.to = bus.rsp_timeout; stall_v.tag = bus.rsp_tag;
            end
        end else begin
            if (stall_seen) check("rsp_valid_dropped", 0, 1);
            stall_seen = 1'b0;
        end
    end

    // Calculator-side monitor: operand stability, start/done ordering, timeout length.
    logic        prev_start = 1'b0;
    logic        prev_done = 1'b0;
    logic [33:0] prev_ops = '0;
    int          run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start = 1'b0; run = 0;
        end else begin
            if (calc_start) begin
                if (!prev_start) check("start_rise_done_low", calc_done, 0);
                else check("ops_stable", {calc_op, calc_a, calc_b}, prev_ops);
                run++;
            end else if (prev_start) begin
                if (stub_cur_stuck) check("timeout_start_len", run, TIMEOUT_CYC);
                else check("start_drop_after_done", prev_done, 1);
                run = 0;
            end
            prev_start = calc_start;
        end
        prev_done = calc_done;
        prev_ops  = {calc_op, calc_a, calc_b};
    end

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [TAG_W-1:0] tag, input int budget, output bit ok);
        bit st;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_tag = tag;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                st = (model_stuck_left > 0);
                if (st) model_stuck_left--;
                exp_q.push_back(model(op, a, b, tag, st));
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_must(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [TAG_W-1:0] tag);
        bit ok;
        send(op, a, b, tag, 200, ok);
        check("cmd_accept", ok, 1);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 4000 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !busy;
        end
        check(name, done, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int accepted;
        bit saw_valid;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_tag = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {calc_start, calc_op, calc_a, calc_b, bus.rsp_valid, bus.rsp_result,
              bus.rsp_overflow, bus.rsp_error, bus.rsp_timeout, bus.rsp_tag, busy}, 0);
        check("reset_cmd_ready", bus.cmd_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic pass-through.
        ready_mode = 0;
        send_must(OP_ADD, 16'h1234, 16'h0111, 4'd3);
        send_must(OP_MUL, 16'd300, 16'd300, 4'd5);
        send_must(OP_DIV, 16'd100, 16'd0, 4'd6);
        send_must(OP_DIV, 16'd100, 16'd7, 4'd7);
        send_must(OP_SUB, 16'h0001, 16'h0002, 4'd8);
        drain("drain_directed");

        // Fill with responses stalled: one in flight plus FIFO_DEPTH queued.
        ready_mode = 2;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            send(2'($urandom), 16'($urandom), 16'($urandom_range(1, 500)), TAG_W'(i), 40, ok);
            if (!ok) break;
            accepted++;
        end
        check("fill_accepted", accepted, FIFO_DEPTH + 1);
        check("fill_cmd_ready", bus.cmd_ready, 0);
        check("fill_busy", busy, 1);
        ready_mode = 1;
        drain("drain_fill");

        // Calculator that never answers, followed by a normal command.
        ready_mode = 0;
        model_stuck_left = 1;
        stub_stuck_left = 1;
        send_must(OP_ADD, 16'h0005, 16'h0006, 4'd9);
        send_must(OP_ADD, 16'h0005, 16'h0006, 4'd10);
        drain("drain_timeout");

        // Randomized traffic with random response back-pressure.
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send_must(2'($urandom), 16'($urandom),
                      ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom), TAG_W'($urandom));
        end
        drain("drain_random");

        // Reset five cycles into a MUL with two commands queued.
        ready_mode = 0;
        send_must(OP_MUL, 16'd1000, 16'd77, 4'd1);
        send_must(OP_ADD, 16'd1, 16'd2, 4'd2);
        send_must(OP_SUB, 16'd9, 16'd4, 4'd3);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = calc_start;
        end
        check("mul_started", ok, 1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midop_reset_outputs", {calc_start, calc_op, calc_a, calc_b, bus.rsp_valid, bus.rsp_result,
              bus.rsp_overflow, bus.rsp_error, bus.rsp_timeout, bus.rsp_tag, busy}, 0);
        check("midop_reset_cmd_ready", bus.cmd_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.rsp_valid || calc_start) saw_valid = 1'b1;
        end
        check("post_reset_quiet", saw_valid, 0);
        check("post_reset_busy", busy, 0);

        // New traffic after reset still works.
        @(posedge clk); #1;
        send_must(OP_SUB, 16'd9, 16'd4, 4'd12);
        drain("drain_post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
